// File: rtl/pipelined_tree_multiplier.sv
// rtl/pipelined_tree_multiplier.sv - 3-stage Baugh-Wooley CSA-tree multiplier with prefix adder
// Optional accumulator folded into the final adder when MULT_ACC_EN is defined.
module pipelined_tree_multiplier #(
    parameter int WIDTH     = 8,
    parameter int RED_SPLIT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [WIDTH-1:0]     in_y,
    input  logic                 in_signed,
    input  logic                 in_acc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic                 busy
);
    localparam int P     = 2 * WIDTH;
    localparam int NROWS = WIDTH + 1;

    typedef logic [NROWS-1:0][P-1:0] rows_t;

    function automatic int count_levels(input int n);
        int r;
        int lv;
        r  = n;
        lv = 0;
        while (r > 2) begin
            r  = 2 * (r / 3) + r % 3;
            lv = lv + 1;
        end
        return lv;
    endfunction

    function automatic int rows_after(input int n, input int lv);
        int r;
        r = n;
        for (int l = 0; l < lv; l++) begin
            if (r > 2) r = 2 * (r / 3) + r % 3;
        end
        return r;
    endfunction

    localparam int LV  = count_levels(NROWS);
    localparam int LV1 = (RED_SPLIT == 0) ? LV / 2 : ((RED_SPLIT > LV) ? LV : RED_SPLIT);
    localparam int LV2 = LV - LV1;
    localparam int R1  = rows_after(NROWS, LV1);

    // Each level compresses every group of three rows into a sum row and a
    // shifted carry row; leftover rows pass through untouched.
    function automatic rows_t csa_levels(input rows_t r_in, input int n_in, input int lv);
        rows_t r;
        rows_t nr;
        int    n;
        int    nn;
        r = r_in;
        n = n_in;
        for (int l = 0; l < LV; l++) begin
            if (l < lv && n > 2) begin
                nr = '0;
                nn = 0;
                for (int g = 0; g < NROWS / 3; g++) begin
                    if (3 * g + 2 < n) begin
                        nr[nn]     = r[3*g] ^ r[3*g+1] ^ r[3*g+2];
                        nr[nn + 1] = ((r[3*g] & r[3*g+1]) | (r[3*g] & r[3*g+2]) |
                                      (r[3*g+1] & r[3*g+2])) << 1;
                        nn = nn + 2;
                    end
                end
                for (int i = 0; i < NROWS; i++) begin
                    if (i >= 3 * (n / 3) && i < n) begin
                        nr[nn] = r[i];
                        nn = nn + 1;
                    end
                end
                r = nr;
                n = nn;
            end
        end
        return r;
    endfunction

    // Kogge-Stone style prefix carry network.
    function automatic logic [P-1:0] prefix_add(input logic [P-1:0] a, input logic [P-1:0] b);
        logic [P-1:0] g;
        logic [P-1:0] p;
        logic [P-1:0] hs;
        g  = a & b;
        p  = a ^ b;
        hs = p;
        for (int d = 1; d < P; d = d * 2) begin
            g = g | (p & (g << d));
            p = p & (p << d);
        end
        return hs ^ (g << 1);
    endfunction

    logic         s1_valid_q;
    logic         s2_valid_q;
    logic         s3_valid_q;
    logic [P-1:0] out_p_q;
    rows_t        s1_rows_q;
    logic [P-1:0] s2_a_q;
    logic [P-1:0] s2_b_q;

    logic         s3_adv;
    logic         s2_open;
    logic         s2_load;
    logic         s3_load;
    logic         accept;

    assign s3_adv    = !s3_valid_q || out_ready;
    assign s3_load   = s2_valid_q && s3_adv;
    assign s2_open   = !s2_valid_q || s3_adv;
    assign s2_load   = s1_valid_q && s2_open;
    assign in_ready  = !s1_valid_q || s2_open;
    assign accept    = in_valid && in_ready;

    assign out_valid = s3_valid_q;
    assign out_p     = out_p_q;
    assign busy      = s1_valid_q | s2_valid_q | s3_valid_q;

    // Baugh-Wooley: cross terms touching exactly one operand MSB are inverted,
    // and the correction constants ride in an extra row.
    rows_t pp;
    always_comb begin
        pp = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                pp[i][i+j] = (in_x[j] & in_y[i]) ^
                             (in_signed & ((i == WIDTH - 1) != (j == WIDTH - 1)));
            end
        end
        if (in_signed) begin
            pp[WIDTH][WIDTH] = 1'b1;
            pp[WIDTH][P-1]   = 1'b1;
        end
    end

    rows_t red1;
    rows_t red2;
    logic  unused_rows;
    assign red1        = csa_levels(pp, NROWS, LV1);
    assign red2        = csa_levels(s1_rows_q, R1, LV2);
    assign unused_rows = ^red2[NROWS-1:2];

    logic [P-1:0] s3_sum;

`ifdef MULT_ACC_EN
    logic         s1_acc_q;
    logic         s2_acc_q;
    logic [P-1:0] acc_q;
    logic [P-1:0] acc_in;
    logic [P-1:0] fa_s;
    logic [P-1:0] fa_c;

    assign acc_in = s2_acc_q ? acc_q : '0;
    assign fa_s   = s2_a_q ^ s2_b_q ^ acc_in;
    assign fa_c   = ((s2_a_q & s2_b_q) | (s2_a_q & acc_in) | (s2_b_q & acc_in)) << 1;
    assign s3_sum = prefix_add(fa_s, fa_c);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_acc_q <= 1'b0;
            s2_acc_q <= 1'b0;
            acc_q    <= '0;
        end else begin
            if (accept)  s1_acc_q <= in_acc;
            if (s2_load) s2_acc_q <= s1_acc_q;
            if (s3_load) acc_q    <= s3_sum;
        end
    end
`else
    logic unused_acc;
    assign unused_acc = in_acc;
    assign s3_sum     = prefix_add(s2_a_q, s2_b_q);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            out_p_q    <= '0;
        end else begin
            if (in_ready) s1_valid_q <= in_valid;
            if (s2_open)  s2_valid_q <= s1_valid_q;
            if (s3_adv)   s3_valid_q <= s2_valid_q;
            if (s3_load)  out_p_q    <= s3_sum;
        end
    end

    // Datapath registers load only with a valid transaction so idle X never enters.
    always_ff @(posedge clk) begin
        if (accept) s1_rows_q <= red1;
        if (s2_load) begin
            s2_a_q <= red2[0];
            s2_b_q <= red2[1];
        end
    end
endmodule

// File: tb/tb_pipelined_tree_multiplier.sv
// tb/tb_pipelined_tree_multiplier.sv - scoreboard bench for pipelined_tree_multiplier at WIDTH=4
module tb_pipelined_tree_multiplier;
    localparam int W = 4;
    localparam int P = 2 * W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_signed = 1'b0;
    logic         in_acc = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] in_x = '0;
    logic [W-1:0] in_y = '0;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [P-1:0] out_p;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cnt = 0;
    bit chk_lat = 1'b0;
    bit any_valid = 1'b0;
    logic [P-1:0] acc_m = '0;

    typedef struct {
        logic [P-1:0] p;
        int           t;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    pipelined_tree_multiplier #(.WIDTH(W), .RED_SPLIT(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_signed (in_signed),
        .in_acc    (in_acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    function automatic logic [P-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic s);
        logic [P-1:0] xe;
        logic [P-1:0] ye;
        xe = s ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
        ye = s ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
        return xe * ye;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic s, input logic a, input logic ordy);
        exp_t         e;
        logic [P-1:0] prod;
        @(negedge clk);
        in_valid  = v;
        in_x      = x;
        in_y      = y;
        in_signed = s;
        in_acc    = a;
        out_ready = ordy;
        #1;
        any_valid = any_valid | out_valid;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_result", 32'(out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("result", 32'(out_p), 32'(e.p));
                if (chk_lat) check("latency", 32'(cyc - e.t), 32'd3);
            end
        end
        if (in_valid && in_ready) begin
            prod = ref_mul(x, y, s);
`ifdef MULT_ACC_EN
            acc_m = a ? acc_m + prod : prod;
            e.p = acc_m;
`else
            e.p = prod;
`endif
            e.t = cyc;
            sb.push_back(e);
            acc_cnt++;
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_p", 32'(out_p), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        acc_m = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        logic [P-1:0] held;
        int           n0;

        do_reset(2);

        chk_lat = 1'b1;
        step(1'b1, 4'd15, 4'd15, 1'b0, 1'b0, 1'b1);
        step(1'b1, 4'd0,  4'd9,  1'b0, 1'b0, 1'b1);
        step(1'b1, 4'h8,  4'h8,  1'b1, 1'b0, 1'b1);
        step(1'b1, 4'h8,  4'h7,  1'b1, 1'b0, 1'b1);
        step(1'b1, 4'hF,  4'h1,  1'b1, 1'b0, 1'b1);
        step(1'b1, 4'h8,  4'h8,  1'b0, 1'b0, 1'b1);
        drain();

        for (int i = 0; i < 16; i++) begin
            rx = W'($urandom);
            ry = W'($urandom);
            step(1'b1, rx, ry, 1'($urandom), 1'b0, 1'b1);
        end
        drain();

        chk_lat = 1'b0;
        n0 = acc_cnt;
        for (int i = 0; i < 5; i++) begin
            rx = W'($urandom);
            ry = W'($urandom);
            step(1'b1, rx, ry, 1'($urandom), 1'b0, 1'b0);
        end
        check("bp_accepts", 32'(acc_cnt - n0), 32'd3);
        @(negedge clk);
        #1;
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        held = out_p;
        check("bp_front", 32'(out_p), 32'(sb[0].p));
        @(negedge clk);
        #1;
        check("bp_out_p_stable", 32'(out_p), 32'(held));
        drain();

        chk_lat = 1'b1;
        step(1'b1, 4'd7, 4'd9, 1'b0, 1'b0, 1'b1);
        step(1'b1, 4'd5, 4'd3, 1'b1, 1'b0, 1'b1);
        do_reset(1);
        any_valid = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        check("no_stale_after_reset", 32'(any_valid), 32'd0);

`ifdef MULT_ACC_EN
        chk_lat = 1'b0;
        step(1'b1, 4'd3,  4'd5,  1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd2,  4'd2,  1'b0, 1'b1, 1'b0);
        step(1'b1, 4'd15, 4'd15, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
